// File: rtl/fakeram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fakeram_fifo_pkg
// Purpose  : Default geometry shared by the fakeram-backed FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
package fakeram_fifo_pkg;

  localparam int DEF_BITS       = 64;
  localparam int DEF_WORD_DEPTH = 64;
  localparam int DEF_ADDR_WIDTH = 6;

  localparam int COUNT_W = DEF_ADDR_WIDTH + 1;
  localparam int LEVEL_W = DEF_ADDR_WIDTH + 2;

endpackage
`default_nettype wire

// File: rtl/fakeram_fifo_obuf.sv
`default_nettype none
// ============================================================================
// Module   : fakeram_fifo_obuf
// Purpose  : Two-entry output buffer that absorbs the SRAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module fakeram_fifo_obuf
  import fakeram_fifo_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_cap_valid,
  input  logic [BITS-1:0] i_cap_data,
  input  logic            i_pop,
  output logic [1:0]      o_count,
  output logic            o_head_valid,
  output logic [BITS-1:0] o_head_data
);

  logic [BITS-1:0] r_head;
  logic [BITS-1:0] r_tail;
  logic [1:0]      r_count;
  logic            w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  // Head always lives in r_head, so a pop shifts the tail forward.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_cap_valid, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_cap_data;
          else                 r_tail <= i_cap_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_cap_data;
          end else begin
            r_head <= i_cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head_data  = r_head;

endmodule
`default_nettype wire

// File: rtl/fakeram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fakeram_fifo_ctrl
// Purpose  : FWFT FIFO controller over a 1rw1r fakeram macro (rw0 writes, r0 reads).
// Revision : 1.0 - initial release
// ============================================================================
module fakeram_fifo_ctrl
  import fakeram_fifo_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  mem_w_ce,
  output logic                  mem_w_we,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [BITS-1:0]       mem_w_data,
  output logic                  mem_r_ce,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [BITS-1:0]       mem_r_data
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int LVL_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_mem_count;
  logic                  r_inflight;

  logic       w_wr;
  logic       w_rd_fire;
  logic       w_pop;
  logic [1:0] w_obuf_count;
  logic [2:0] w_occ;

  assign in_ready = !sys_rst && !flush && (r_mem_count < C_FULL);
  assign w_wr     = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  // Buffer slots that will be committed after this edge; a pop implies
  // obuf_count >= 1, so the subtraction cannot underflow.
  assign w_occ     = {1'b0, w_obuf_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_fire = !sys_rst && !flush && (r_mem_count != '0) && (w_occ < 3'd2);

  assign mem_w_ce   = w_wr;
  assign mem_w_we   = w_wr;
  assign mem_w_addr = r_wr_ptr;
  assign mem_w_data = in_data;
  assign mem_r_ce   = w_rd_fire;
  assign mem_r_addr = r_rd_ptr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_wr)      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_count <= r_mem_count + CNT_W'(w_wr) - CNT_W'(w_rd_fire);
      r_inflight  <= w_rd_fire;
    end
  end

  fakeram_fifo_obuf #(
    .BITS (BITS)
  ) u_obuf (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .i_flush      (flush),
    .i_cap_valid  (r_inflight),
    .i_cap_data   (mem_r_data),
    .i_pop        (w_pop),
    .o_count      (w_obuf_count),
    .o_head_valid (out_valid),
    .o_head_data  (out_data)
  );

  assign level = LVL_W'(r_mem_count) + LVL_W'(r_inflight) + LVL_W'(w_obuf_count);

endmodule
`default_nettype wire

// File: tb/tb_fakeram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fakeram_fifo_ctrl
// Purpose  : Directed and random-backpressure bench with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fakeram_fifo_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  level;
  logic        mem_w_ce;
  logic        mem_w_we;
  logic [5:0]  mem_w_addr;
  logic [63:0] mem_w_data;
  logic        mem_r_ce;
  logic [5:0]  mem_r_addr;
  logic [63:0] mem_r_data;

  logic [63:0] sram [64];
  bit   [63:0] written;

  logic [63:0] q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_acc    = 0;

  fakeram_fifo_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .mem_w_ce   (mem_w_ce),
    .mem_w_we   (mem_w_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_ce   (mem_r_ce),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One-cycle-latency SRAM model of the fakeram macro.
  always @(posedge sys_clk) begin
    if (mem_w_ce && mem_w_we) begin
      sram[mem_w_addr]    <= mem_w_data;
      written[mem_w_addr] <= 1'b1;
    end
    if (mem_r_ce) mem_r_data <= sram[mem_r_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge and score the handshakes that the
  // following rising edge will perform.
  task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    @(negedge sys_clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_eq("level", 64'(level), 64'(q.size()));
    if (mem_r_ce) check_eq("rd_written", 64'(written[mem_r_addr]), 64'd1);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check_eq("pop_empty_model", 64'(out_valid), 64'd0);
      else begin
        check_eq("out_data", out_data, q[0]);
        void'(q.pop_front());
      end
      n_pop++;
    end
    if (in_valid && in_ready) begin
      q.push_back(d);
      n_acc++;
    end
    if (fl) q.delete();
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (q.size() > 0 && b < budget) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      b++;
    end
    if (q.size() > 0) check_eq("drain_timeout", 64'(q.size()), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc0;
    int pops0;
    int first;
    int bubbles;

    sys_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset held for two edges.
    @(negedge sys_clk); #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge sys_clk); #1;
    check_eq("rst_ce", 64'({mem_w_ce, mem_w_we, mem_r_ce}), 64'd0);
    check_eq("rst_level2", 64'(level), 64'd0);
    sys_rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single word, latency of two edges.
    cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("sw_valid_e0", 64'(out_valid), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("sw_valid_e1", 64'(out_valid), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("sw_valid_e2", 64'(out_valid), 64'd1);
    check_eq("sw_data", out_data, 64'hDEAD_BEEF_0000_0001);
    check_eq("sw_level", 64'(level), 64'd1);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("sw_pop_level", 64'(level), 64'd0);
    check_eq("sw_pop_valid", 64'(out_valid), 64'd0);

    // Fill to full with no consumer.
    acc0 = n_acc;
    for (int i = 0; i < 70; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    check_eq("full_accepted", 64'(n_acc - acc0), 64'd66);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("full_level", 64'(level), 64'd66);
    pops0 = n_pop;
    drain(200);
    check_eq("full_drained", 64'(n_pop - pops0), 64'd66);
    check_eq("full_empty_level", 64'(level), 64'd0);

    // Back-to-back streaming across several pointer wraps.
    first = -1; bubbles = 0; pops0 = n_pop;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0);
      if (first < 0 && out_valid) first = i;
      else if (first >= 0 && !out_valid) bubbles++;
    end
    for (int j = 0; j < 10 && (n_pop - pops0) < 200; j++) begin
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      if ((n_pop - pops0) < 200 && !out_valid) bubbles++;
    end
    check_eq("stream_latency", 64'(first), 64'd3);
    check_eq("stream_bubbles", 64'(bubbles), 64'd0);
    check_eq("stream_count", 64'(n_pop - pops0), 64'd200);
    drain(10);

    // Random valid/ready at 50%.
    for (int i = 0; i < 5000; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      check_eq("rnd_level_max", 64'(level <= 8'd66), 64'd1);
      if (level < 8'd64) check_eq("rnd_in_ready", 64'(in_ready), 64'd1);
    end
    drain(200);
    check_eq("rnd_end_level", 64'(level), 64'd0);

    // Flush while a read is in flight.
    for (int i = 0; i < 11; i++) cycle(1'b1, 64'h500 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("fl_level11", 64'(level), 64'd11);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b1);
    check_eq("fl_level10", 64'(level), 64'd10);
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    check_eq("fl_ce", 64'({mem_w_ce, mem_r_ce}), 64'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("fl_after_level", 64'(level), 64'd0);
    check_eq("fl_after_valid", 64'(out_valid), 64'd0);
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check_eq("fl_new_valid", 64'(out_valid), 64'd1);
    check_eq("fl_new_data", out_data, 64'h1234_5678_9ABC_DEF0);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
